// File: rtl/pending_bit_server_pkg.sv
// Shared types and helpers for the pending-bit server: state encoding,
// one-hot to binary index conversion and population count.
package pending_bit_server_pkg;

    // Helpers operate on a fixed maximum width; callers zero-extend narrower words.
    localparam int unsigned MAXW = 64;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    function automatic int unsigned onehot_to_index(input logic [MAXW-1:0] v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            if (v[i]) r = r | i;
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [MAXW-1:0] v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            r = r + 32'(v[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/pending_bit_server_if.sv
// Event input, grant output and status signals of the pending-bit server.
interface pending_bit_server_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDXW  = 4
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_bits;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [IDXW-1:0]  out_index;
    logic [WIDTH-1:0] pending;
    logic [IDXW:0]    pending_cnt;

    modport master (
        output in_valid, in_bits, flush, out_ready,
        input  out_valid, out_onehot, out_index, pending, pending_cnt
    );

    modport slave (
        input  in_valid, in_bits, flush, out_ready,
        output out_valid, out_onehot, out_index, pending, pending_cnt
    );
endinterface

// File: rtl/pending_bit_server_lowest_one_mask.sv
// Isolates the lowest set bit of a word; an all-zero word yields zero.
module lowest_one_mask #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    // Two's-complement trick: in & -in keeps only the lowest set bit.
    assign out = in & (~in + WIDTH'(1));
endmodule

// File: rtl/pending_bit_server.sv
// Accumulates event bits into a pending register and serves them one at a
// time, lowest bit first, as a registered one-hot grant plus binary index.
module pending_bit_server
    import pending_bit_server_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDXW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pending_bit_server_if.slave  bus
);
    localparam int unsigned CNTW = IDXW + 1;

    state_t           state;
    logic             valid_q;
    logic [WIDTH-1:0] onehot_q;
    logic [IDXW-1:0]  index_q;
    logic [WIDTH-1:0] pending_q;
    logic [CNTW-1:0]  cnt_q;

    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] pending_nxt;
    logic             free;

    lowest_one_mask #(.WIDTH(WIDTH)) u_lowest (
        .in  (pending_q),
        .out (sel)
    );

    // While presenting, out_valid is high, so a handshake reduces to out_ready.
    assign free = (state == ST_EMPTY) || bus.out_ready;

    // Removal is applied before the OR so a same-edge set of the moved bit wins.
    always_comb begin
        pending_nxt = pending_q & ~(free ? sel : '0);
        if (bus.in_valid) begin
            pending_nxt = pending_nxt | bus.in_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state     <= ST_EMPTY;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            index_q   <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_nxt;
            cnt_q     <= CNTW'(popcount(MAXW'(pending_nxt)));
            if (free) begin
                if (sel != '0) begin
                    state    <= ST_PRESENT;
                    valid_q  <= 1'b1;
                    onehot_q <= sel;
                    index_q  <= IDXW'(onehot_to_index(MAXW'(sel)));
                end else begin
                    state    <= ST_EMPTY;
                    valid_q  <= 1'b0;
                    onehot_q <= '0;
                    index_q  <= '0;
                end
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_onehot  = onehot_q;
    assign bus.out_index   = index_q;
    assign bus.pending     = pending_q;
    assign bus.pending_cnt = cnt_q;

endmodule
